uart_tx: RTL and testbench

- Serial UART transmitter. Converts parallel bytes from the tx bus side (tx_load / tx_data / tx_ready) into an asynchronous serial frame on the tx line.
- It is the transmit-direction counterpart of the existing UART receive path, and sits between the PDP-8 I/O device logic and the board TX pin.
- It uses a one-byte holding register in front of the shift register, so back-to-back frames go out with no idle gap.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_baud_gen.sv | 32 +++
 rtl/uart_tx.sv | 165 ++++++++++++++++
 tb/tb_uart_tx.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit and receive paths.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_t;

    // Clocks per bit, rounded to the nearest integer.
    function automatic int calc_divisor(input longint clk_freq, input longint baud);
        return int'((clk_freq + (baud / 2)) / baud);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period down-counter. tick is high for the one cycle the count sits at
// zero; the counter then reloads DIVISOR-1. restart forces a fresh period.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int DIVISOR = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [W-1:0] RELOAD = W'(DIVISOR - 1);

    logic [W-1:0] count;

    // Count down, reloading on terminal count or on an explicit restart.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (restart || (count == '0)) begin
            count <= RELOAD;
        end else begin
            count <= count - W'(1);
        end
    end

    assign tick = (count == '0);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one-byte holding register feeding a shift register, so a
// byte loaded during a frame goes out immediately after its last stop bit.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD      = 115200,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_load,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx
);

    localparam int DIVISOR = calc_divisor(CLK_FREQ, BAUD);
    localparam logic [2:0] LAST_BIT  = 3'(UART_DATA_BITS - 1);
    localparam logic       STOP_LAST = 1'(STOP_BITS - 1);

    if (DIVISOR < 2) begin : g_bad_divisor
        $error("uart_tx: DIVISOR must be at least 2");
    end
    if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_stop
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end
    if ((PARITY < 0) || (PARITY > 2)) begin : g_bad_parity
        $error("uart_tx: PARITY must be 0, 1 or 2");
    end

    uart_tx_state_t state, state_n;
    logic [7:0] shifter, shifter_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic       stop_cnt, stop_cnt_n;
    logic       par_bit, par_bit_n;
    logic       tx_n;
    logic       busy_n;
    logic [7:0] hold;
    logic       hold_valid;
    logic       take;
    logic       tick;

    uart_baud_gen #(.DIVISOR(DIVISOR)) baud_gen (
        .clk     (clk),
        .rst     (rst),
        .restart (take),
        .tick    (tick)
    );

    assign tx_ready = !hold_valid;

    // Holding register: filled by an accepted load, emptied by a transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold       <= '0;
            hold_valid <= 1'b0;
        end else if (take) begin
            hold_valid <= 1'b0;
        end else if (tx_load && !hold_valid) begin
            hold       <= tx_data;
            hold_valid <= 1'b1;
        end
    end

    // FSM, shifter and line registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            shifter  <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            par_bit  <= 1'b0;
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
        end else begin
            state    <= state_n;
            shifter  <= shifter_n;
            bit_cnt  <= bit_cnt_n;
            stop_cnt <= stop_cnt_n;
            par_bit  <= par_bit_n;
            tx       <= tx_n;
            tx_busy  <= busy_n;
        end
    end

    // Next state and next line level; tx only moves on bit boundaries.
    always_comb begin
        state_n    = state;
        shifter_n  = shifter;
        bit_cnt_n  = bit_cnt;
        stop_cnt_n = stop_cnt;
        par_bit_n  = par_bit;
        tx_n       = tx;
        take       = 1'b0;
        case (state)
            IDLE: begin
                tx_n = 1'b1;
                take = hold_valid;
            end
            START: begin
                if (tick) begin
                    state_n   = DATA;
                    bit_cnt_n = '0;
                    tx_n      = shifter[0];
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_cnt == LAST_BIT) begin
                        if (PARITY != PAR_NONE) begin
                            state_n = uart_pkg::PARITY;
                            tx_n    = par_bit;
                        end else begin
                            state_n    = STOP;
                            stop_cnt_n = 1'b0;
                            tx_n       = 1'b1;
                        end
                    end else begin
                        bit_cnt_n = bit_cnt + 3'd1;
                        shifter_n = {1'b0, shifter[7:1]};
                        tx_n      = shifter[1];
                    end
                end
            end
            uart_pkg::PARITY: begin
                if (tick) begin
                    state_n    = STOP;
                    stop_cnt_n = 1'b0;
                    tx_n       = 1'b1;
                end
            end
            STOP: begin
                if (tick) begin
                    if (stop_cnt == STOP_LAST) begin
                        if (hold_valid) begin
                            take = 1'b1;
                        end else begin
                            state_n = IDLE;
                            tx_n    = 1'b1;
                        end
                    end else begin
                        stop_cnt_n = 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
            end
        endcase
        // Parity is taken from the whole byte as it leaves the holding register.
        if (take) begin
            state_n   = START;
            shifter_n = hold;
            bit_cnt_n = '0;
            par_bit_n = (PARITY == PAR_ODD) ? ~(^hold) : (^hold);
            tx_n      = 1'b0;
        end
        busy_n = (state_n != IDLE);
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four instances (no parity / even / odd / two stop bits)
// at 16 clocks per bit, a per-channel line-level queue model, a serial
// decoder with scoreboard on channel 0, and directed literal checks.
module tb_uart_tx;

    localparam int DIV = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tx_load [4];
    logic [7:0] tx_data [4];
    logic       tx_ready[4];
    logic       tx_busy [4];
    logic       tx_line [4];

    int n_cmp = 0;
    int n_err = 0;
    int dec_cnt = 0;
    logic [7:0] sb[$];

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 4; g++) begin : gen_ch
        localparam int P = (g == 1) ? 2 : ((g == 2) ? 1 : 0);
        localparam int S = (g == 3) ? 2 : 1;

        uart_tx #(.CLK_FREQ(160), .BAUD(10), .PARITY(P), .STOP_BITS(S)) dut (
            .clk      (clk),
            .rst      (rst),
            .tx_load  (tx_load[g]),
            .tx_data  (tx_data[g]),
            .tx_ready (tx_ready[g]),
            .tx_busy  (tx_busy[g]),
            .tx       (tx_line[g])
        );

        // Model: q holds the line level for the current and upcoming clocks.
        logic       q[$];
        bit         hold_full = 1'b0;
        logic [7:0] hold_byte = 8'h00;

        // Advance the model one clock: consume a level, start a frame, accept.
        always @(posedge clk or posedge rst) begin
            if (rst) begin
                q.delete();
                hold_full = 1'b0;
                if (g == 0) sb.delete();
            end else begin
                if (q.size() > 0) void'(q.pop_front());
                if (q.size() == 0 && hold_full) begin
                    int ones;
                    logic pb;
                    for (int k = 0; k < DIV; k++) q.push_back(1'b0);
                    for (int i = 0; i < 8; i++)
                        for (int k = 0; k < DIV; k++) q.push_back(hold_byte[i]);
                    if (P != 0) begin
                        ones = $countones(hold_byte);
                        pb = (P == 1) ? (ones % 2 == 0) : (ones % 2 == 1);
                        for (int k = 0; k < DIV; k++) q.push_back(pb);
                    end
                    for (int k = 0; k < S * DIV; k++) q.push_back(1'b1);
                    hold_full = 1'b0;
                end else if (!hold_full && tx_load[g]) begin
                    hold_full = 1'b1;
                    hold_byte = tx_data[g];
                    if (g == 0) sb.push_back(tx_data[g]);
                end
            end
        end

        // Compare DUT outputs to the model every cycle.
        always @(negedge clk) begin
            chk($sformatf("ch%0d_tx", g), tx_line[g], (q.size() > 0) ? q[0] : 1'b1);
            chk($sformatf("ch%0d_ready", g), tx_ready[g], !hold_full);
            chk($sformatf("ch%0d_busy", g), tx_busy[g], q.size() > 0);
        end
    end

    // Serial decoder on channel 0 (8N1): mid-bit sampling against the scoreboard.
    bit         dact = 1'b0;
    int         dcnt = 0;
    logic [7:0] dbyte = 8'h00;
    always @(negedge clk) begin
        if (rst) begin
            dact = 1'b0;
        end else if (!dact) begin
            if (tx_line[0] == 1'b0) begin
                dact = 1'b1;
                dcnt = 0;
            end
        end else begin
            dcnt++;
            for (int i = 1; i <= 8; i++)
                if (dcnt == DIV * i + DIV / 2) dbyte[i-1] = tx_line[0];
            if (dcnt == DIV * 9 + DIV / 2) begin
                chk("dec_stop", tx_line[0], 1'b1);
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL dec_unexpected: got byte %0h expected none", dbyte);
                end else begin
                    chk("dec_byte", dbyte, sb.pop_front());
                end
                dec_cnt++;
                dact = 1'b0;
            end
        end
    end

    task automatic load(input int g, input logic [7:0] d);
        @(negedge clk);
        tx_load[g] = 1'b1;
        tx_data[g] = d;
        @(negedge clk);
        tx_load[g] = 1'b0;
    endtask

    // Send one byte from idle and pin its waveform to a hand-written pattern
    // (pat[i] = level of bit slot i).
    task automatic run_frame(input int g, input logic [7:0] d, input logic [15:0] pat,
                             input int nbits, input string nm);
        int   len;
        logic samp[$];
        logic bsy[$];
        len = nbits * DIV;
        load(g, d);
        chk({nm, "_pre_tx"}, tx_line[g], 1'b1);
        chk({nm, "_pre_ready"}, tx_ready[g], 1'b0);
        @(negedge clk);
        chk({nm, "_fall_ready"}, tx_ready[g], 1'b1);
        for (int k = 0; k <= len; k++) begin
            samp.push_back(tx_line[g]);
            bsy.push_back(tx_busy[g]);
            @(negedge clk);
        end
        for (int i = 0; i < nbits; i++) begin
            chk($sformatf("%s_bit%0d_first", nm, i), samp[i*DIV], pat[i]);
            chk($sformatf("%s_bit%0d_last", nm, i), samp[i*DIV+DIV-1], pat[i]);
        end
        chk({nm, "_busy_last"}, bsy[len-1], 1'b1);
        chk({nm, "_busy_end"}, bsy[len], 1'b0);
        chk({nm, "_idle_tx"}, samp[len], 1'b1);
    endtask

    initial begin
        int lows;
        int t;
        for (int i = 0; i < 4; i++) begin
            tx_load[i] = 1'b0;
            tx_data[i] = 8'h00;
        end

        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rst_tx%0d", i), tx_line[i], 1'b1);
            chk($sformatf("rst_ready%0d", i), tx_ready[i], 1'b1);
            chk($sformatf("rst_busy%0d", i), tx_busy[i], 1'b0);
        end
        #2 rst = 1'b0;
        @(negedge clk);

        run_frame(0, 8'h55, 16'h02AA, 10, "n1_55");
        run_frame(1, 8'h07, 16'h060E, 11, "even_07");
        run_frame(2, 8'h07, 16'h040E, 11, "odd_07");

        // Back-to-back with two stop bits, plus an overrun attempt.
        load(3, 8'hA3);
        @(negedge clk);
        chk("b2b_fall", tx_line[3], 1'b0);
        for (int k = 0; k <= 352; k++) begin
            if (k == 1) begin
                chk("b2b_ready_k1", tx_ready[3], 1'b1);
                tx_load[3] = 1'b1;
                tx_data[3] = 8'h3C;
            end
            if (k == 2) begin
                tx_load[3] = 1'b0;
                chk("b2b_held", tx_ready[3], 1'b0);
            end
            if (k == 5) begin
                tx_load[3] = 1'b1;
                tx_data[3] = 8'hFF;
            end
            if (k == 6) tx_load[3] = 1'b0;
            if (k == 100) chk("ovr_ready_mid", tx_ready[3], 1'b0);
            if (k == 175) begin
                chk("b2b_stop_end_tx", tx_line[3], 1'b1);
                chk("b2b_stop_end_ready", tx_ready[3], 1'b0);
            end
            if (k == 176) begin
                chk("b2b_start2_tx", tx_line[3], 1'b0);
                chk("b2b_start2_ready", tx_ready[3], 1'b1);
                chk("b2b_start2_busy", tx_busy[3], 1'b1);
            end
            if (k == 176 + DIV + DIV / 2) chk("b2b_3c_bit0", tx_line[3], 1'b0);
            if (k == 176 + 3 * DIV + DIV / 2) chk("b2b_3c_bit2", tx_line[3], 1'b1);
            if (k == 352) begin
                chk("b2b_done_tx", tx_line[3], 1'b1);
                chk("b2b_done_busy", tx_busy[3], 1'b0);
            end
            @(negedge clk);
        end

        // Reset at clock 40 of a frame with another byte already held.
        load(0, 8'h0D);
        @(negedge clk);
        for (int k = 0; k < 40; k++) begin
            if (k == 2) begin
                tx_load[0] = 1'b1;
                tx_data[0] = 8'h81;
            end
            if (k == 3) tx_load[0] = 1'b0;
            @(negedge clk);
        end
        chk("rst_mid_pre_tx", tx_line[0], 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_tx", tx_line[0], 1'b1);
        chk("rst_mid_ready", tx_ready[0], 1'b1);
        chk("rst_mid_busy", tx_busy[0], 1'b0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        lows = 0;
        repeat (250) begin
            @(negedge clk);
            if (!tx_line[0]) lows++;
        end
        chk("rst_mid_no_frame", lows, 0);

        // Random bytes with random gaps and occasional ignored loads.
        for (int n = 0; n < 200; n++) begin
            int gap;
            gap = $urandom_range(0, 30);
            repeat (gap) @(negedge clk);
            if (!tx_ready[0] && ($urandom_range(0, 1) == 1)) begin
                tx_load[0] = 1'b1;
                tx_data[0] = 8'($urandom);
                @(negedge clk);
                tx_load[0] = 1'b0;
            end
            t = 0;
            while (!tx_ready[0] && t < 400) begin
                @(negedge clk);
                t++;
            end
            if (!tx_ready[0]) begin
                n_cmp++;
                n_err++;
                $display("FAIL rand_ready_timeout: got ready 0 expected 1 at byte %0d", n);
            end
            tx_load[0] = 1'b1;
            tx_data[0] = 8'($urandom);
            @(negedge clk);
            tx_load[0] = 1'b0;
        end

        t = 0;
        while ((tx_busy[0] || !tx_ready[0]) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        repeat (5) @(negedge clk);
        chk("rand_drain_busy", tx_busy[0], 1'b0);
        chk("rand_sb_empty", sb.size(), 0);
        chk("decoded_count", dec_cnt, 201);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
